// File: rtl/sa_write_arbiter_pkg.sv
// Shared definitions for the per-slave write arbiter: default AXI field
// widths, order-FIFO pointer sizing and the round-robin index helpers.
package sa_write_arbiter_pkg;

    localparam int MST_AMT_DEF           = 2;
    localparam int OUTSTANDING_AMT_DEF   = 8;
    localparam int DATA_WIDTH_DEF        = 32;
    localparam int ADDR_WIDTH_DEF        = 32;
    localparam int TRANS_MST_ID_W_DEF    = 5;
    localparam int TRANS_BURST_W_DEF     = 2;
    localparam int TRANS_DATA_LEN_W_DEF  = 3;
    localparam int TRANS_DATA_SIZE_W_DEF = 3;
    localparam int TRANS_WR_RESP_W_DEF   = 2;

    // Order-FIFO pointer width: index bits plus one wrap bit.
    function automatic int outst_ctn_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int OUTST_CTN_W = outst_ctn_w(OUTSTANDING_AMT_DEF);

    // Width of a master index; never allowed to collapse to zero bits.
    function automatic int mst_idx_w(input int amt);
        return (amt > 1) ? $clog2(amt) : 1;
    endfunction

    // Round-robin successor of idx, wrapping modulo amt.
    function automatic int rr_next(input int idx, input int amt);
        return (idx + 1 >= amt) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sa_write_arbiter_if.sv
// Bundle of all dispatcher-side and slave-side AW/W/B signals of one
// arbiter instance. The slave modport is the arbiter's view; the master
// modport is the view of the surrounding dispatchers and AXI slave.
interface sa_write_arbiter_if
    import sa_write_arbiter_pkg::*;
#(
    parameter int MST_AMT           = MST_AMT_DEF,
    parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH        = ADDR_WIDTH_DEF,
    parameter int TRANS_MST_ID_W    = TRANS_MST_ID_W_DEF,
    parameter int TRANS_BURST_W     = TRANS_BURST_W_DEF,
    parameter int TRANS_DATA_LEN_W  = TRANS_DATA_LEN_W_DEF,
    parameter int TRANS_DATA_SIZE_W = TRANS_DATA_SIZE_W_DEF,
    parameter int TRANS_WR_RESP_W   = TRANS_WR_RESP_W_DEF
);
    // Dispatcher AW
    logic [TRANS_MST_ID_W*MST_AMT-1:0]    dsp_AWID_i;
    logic [ADDR_WIDTH*MST_AMT-1:0]        dsp_AWADDR_i;
    logic [TRANS_BURST_W*MST_AMT-1:0]     dsp_AWBURST_i;
    logic [TRANS_DATA_LEN_W*MST_AMT-1:0]  dsp_AWLEN_i;
    logic [TRANS_DATA_SIZE_W*MST_AMT-1:0] dsp_AWSIZE_i;
    logic [MST_AMT-1:0]                   dsp_AWVALID_i;
    logic [MST_AMT-1:0]                   dsp_AW_outst_full_i;
    logic [MST_AMT-1:0]                   dsp_AWREADY_o;
    // Dispatcher W
    logic [DATA_WIDTH*MST_AMT-1:0]        dsp_WDATA_i;
    logic [MST_AMT-1:0]                   dsp_WLAST_i;
    logic [MST_AMT-1:0]                   dsp_WVALID_i;
    logic [MST_AMT-1:0]                   dsp_WREADY_o;
    // Dispatcher B
    logic [TRANS_MST_ID_W-1:0]            dsp_BID_o;
    logic [TRANS_WR_RESP_W-1:0]           dsp_BRESP_o;
    logic [MST_AMT-1:0]                   dsp_BVALID_o;
    logic [MST_AMT-1:0]                   dsp_BREADY_i;
    // Slave AW
    logic [TRANS_MST_ID_W-1:0]            s_AWID_o;
    logic [ADDR_WIDTH-1:0]                s_AWADDR_o;
    logic [TRANS_BURST_W-1:0]             s_AWBURST_o;
    logic [TRANS_DATA_LEN_W-1:0]          s_AWLEN_o;
    logic [TRANS_DATA_SIZE_W-1:0]         s_AWSIZE_o;
    logic                                 s_AWVALID_o;
    logic                                 s_AWREADY_i;
    // Slave W
    logic [DATA_WIDTH-1:0]                s_WDATA_o;
    logic                                 s_WLAST_o;
    logic                                 s_WVALID_o;
    logic                                 s_WREADY_i;
    // Slave B
    logic [TRANS_MST_ID_W-1:0]            s_BID_i;
    logic [TRANS_WR_RESP_W-1:0]           s_BRESP_i;
    logic                                 s_BVALID_i;
    logic                                 s_BREADY_o;

    modport slave (
        input  dsp_AWID_i, dsp_AWADDR_i, dsp_AWBURST_i, dsp_AWLEN_i, dsp_AWSIZE_i,
        input  dsp_AWVALID_i, dsp_AW_outst_full_i,
        output dsp_AWREADY_o,
        input  dsp_WDATA_i, dsp_WLAST_i, dsp_WVALID_i,
        output dsp_WREADY_o,
        output dsp_BID_o, dsp_BRESP_o, dsp_BVALID_o,
        input  dsp_BREADY_i,
        output s_AWID_o, s_AWADDR_o, s_AWBURST_o, s_AWLEN_o, s_AWSIZE_o, s_AWVALID_o,
        input  s_AWREADY_i,
        output s_WDATA_o, s_WLAST_o, s_WVALID_o,
        input  s_WREADY_i,
        input  s_BID_i, s_BRESP_i, s_BVALID_i,
        output s_BREADY_o
    );

    modport master (
        output dsp_AWID_i, dsp_AWADDR_i, dsp_AWBURST_i, dsp_AWLEN_i, dsp_AWSIZE_i,
        output dsp_AWVALID_i, dsp_AW_outst_full_i,
        input  dsp_AWREADY_o,
        output dsp_WDATA_i, dsp_WLAST_i, dsp_WVALID_i,
        input  dsp_WREADY_o,
        input  dsp_BID_o, dsp_BRESP_o, dsp_BVALID_o,
        output dsp_BREADY_i,
        input  s_AWID_o, s_AWADDR_o, s_AWBURST_o, s_AWLEN_o, s_AWSIZE_o, s_AWVALID_o,
        output s_AWREADY_i,
        input  s_WDATA_o, s_WLAST_o, s_WVALID_o,
        output s_WREADY_i,
        output s_BID_i, s_BRESP_i, s_BVALID_i,
        input  s_BREADY_o
    );

endinterface

// File: rtl/sa_order_fifo.sv
// Small FIFO holding granted master indices in AW order. The head is read
// combinationally so W/B steering follows the head in the same cycle.
// A pop on a full FIFO frees the slot for a same-cycle push; a push on an
// empty FIFO is not visible at the head until the following cycle.
module sa_order_fifo
    import sa_write_arbiter_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = outst_ctn_w(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]) &&
                     (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg[IDX_W-1:0]];

    // Pointer update; reset discards every stored entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[IDX_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/sa_write_arbiter.sv
// Per-slave write arbiter: round-robin AW arbitration with a registered
// slave AW stage, W and B steering by recorded grant order, and a cap on
// outstanding write transactions set by the order-FIFO depth.
module sa_write_arbiter
    import sa_write_arbiter_pkg::*;
#(
    parameter int MST_AMT           = MST_AMT_DEF,
    parameter int OUTSTANDING_AMT   = OUTSTANDING_AMT_DEF,
    parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH        = ADDR_WIDTH_DEF,
    parameter int TRANS_MST_ID_W    = TRANS_MST_ID_W_DEF,
    parameter int TRANS_BURST_W     = TRANS_BURST_W_DEF,
    parameter int TRANS_DATA_LEN_W  = TRANS_DATA_LEN_W_DEF,
    parameter int TRANS_DATA_SIZE_W = TRANS_DATA_SIZE_W_DEF,
    parameter int TRANS_WR_RESP_W   = TRANS_WR_RESP_W_DEF,
    parameter int MST_ID_W          = mst_idx_w(MST_AMT)
) (
    input  logic                ACLK_i,
    input  logic                ARESETn_i,
    sa_write_arbiter_if.slave   bus
);
    // Per-master views of the packed dispatcher buses
    logic [TRANS_MST_ID_W-1:0]    mst_awid    [MST_AMT];
    logic [ADDR_WIDTH-1:0]        mst_awaddr  [MST_AMT];
    logic [TRANS_BURST_W-1:0]     mst_awburst [MST_AMT];
    logic [TRANS_DATA_LEN_W-1:0]  mst_awlen   [MST_AMT];
    logic [TRANS_DATA_SIZE_W-1:0] mst_awsize  [MST_AMT];
    logic [DATA_WIDTH-1:0]        mst_wdata   [MST_AMT];

    // Arbitration
    logic [MST_AMT-1:0]  eligible;
    logic [MST_ID_W-1:0] winner;
    logic                winner_found;
    logic                aw_free;
    logic                can_accept;
    logic                grant;
    logic [MST_AMT-1:0]  awready;
    logic [MST_ID_W-1:0] rr_ptr_reg;
    logic [MST_ID_W-1:0] rr_ptr_next;

    // Registered slave AW stage
    logic                         aw_valid_reg;
    logic [TRANS_MST_ID_W-1:0]    aw_id_reg;
    logic [ADDR_WIDTH-1:0]        aw_addr_reg;
    logic [TRANS_BURST_W-1:0]     aw_burst_reg;
    logic [TRANS_DATA_LEN_W-1:0]  aw_len_reg;
    logic [TRANS_DATA_SIZE_W-1:0] aw_size_reg;

    // Order FIFOs
    logic [MST_ID_W-1:0] w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic [MST_ID_W-1:0] b_head;
    logic                b_empty;
    logic                b_full;
    logic                b_pop;

    // Steering
    logic                  s_wvalid;
    logic                  s_wlast;
    logic                  s_bready;
    logic [MST_AMT-1:0]    wready;
    logic [MST_AMT-1:0]    bvalid;

    for (genvar gi = 0; gi < MST_AMT; gi++) begin : g_slice
        assign mst_awid[gi]    = bus.dsp_AWID_i[gi*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        assign mst_awaddr[gi]  = bus.dsp_AWADDR_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign mst_awburst[gi] = bus.dsp_AWBURST_i[gi*TRANS_BURST_W +: TRANS_BURST_W];
        assign mst_awlen[gi]   = bus.dsp_AWLEN_i[gi*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
        assign mst_awsize[gi]  = bus.dsp_AWSIZE_i[gi*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
        assign mst_wdata[gi]   = bus.dsp_WDATA_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Pick the first eligible master at or after the round-robin pointer.
    always_comb begin
        int cand_idx;
        logic [MST_ID_W-1:0] cand_id;
        eligible     = bus.dsp_AWVALID_i & ~bus.dsp_AW_outst_full_i;
        winner       = '0;
        winner_found = 1'b0;
        cand_idx     = 0;
        cand_id      = '0;
        for (int k = 0; k < MST_AMT; k++) begin
            cand_idx = int'(rr_ptr_reg) + k;
            if (cand_idx >= MST_AMT) cand_idx = cand_idx - MST_AMT;
            cand_id = MST_ID_W'(cand_idx);
            if (!winner_found && eligible[cand_id]) begin
                winner_found = 1'b1;
                winner       = cand_id;
            end
        end
    end

    // Accept only when the AW stage drains this cycle and both order FIFOs
    // have room, counting a same-cycle pop as freeing a slot.
    always_comb begin
        aw_free     = !aw_valid_reg || bus.s_AWREADY_i;
        can_accept  = aw_free && (!w_full || w_pop) && (!b_full || b_pop);
        grant       = can_accept && winner_found;
        rr_ptr_next = MST_ID_W'(rr_next(int'(winner), MST_AMT));
        awready     = '0;
        if (grant) awready[winner] = 1'b1;
    end

    // Slave AW register stage and round-robin pointer.
    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            aw_valid_reg <= 1'b0;
            aw_id_reg    <= '0;
            aw_addr_reg  <= '0;
            aw_burst_reg <= '0;
            aw_len_reg   <= '0;
            aw_size_reg  <= '0;
            rr_ptr_reg   <= '0;
        end else if (grant) begin
            aw_valid_reg <= 1'b1;
            aw_id_reg    <= mst_awid[winner];
            aw_addr_reg  <= mst_awaddr[winner];
            aw_burst_reg <= mst_awburst[winner];
            aw_len_reg   <= mst_awlen[winner];
            aw_size_reg  <= mst_awsize[winner];
            rr_ptr_reg   <= rr_ptr_next;
        end else if (bus.s_AWREADY_i) begin
            aw_valid_reg <= 1'b0;
        end
    end

    sa_order_fifo #(
        .WIDTH (MST_ID_W),
        .DEPTH (OUTSTANDING_AMT)
    ) u_w_order (
        .clk       (ACLK_i),
        .rst_n     (ARESETn_i),
        .push      (grant),
        .push_data (winner),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full)
    );

    sa_order_fifo #(
        .WIDTH (MST_ID_W),
        .DEPTH (OUTSTANDING_AMT)
    ) u_b_order (
        .clk       (ACLK_i),
        .rst_n     (ARESETn_i),
        .push      (grant),
        .push_data (winner),
        .pop       (b_pop),
        .head      (b_head),
        .empty     (b_empty),
        .full      (b_full)
    );

    // W steering: only the master at the W-order head sees the slave ready.
    always_comb begin
        s_wvalid = !w_empty && bus.dsp_WVALID_i[w_head];
        s_wlast  = bus.dsp_WLAST_i[w_head];
        wready   = '0;
        if (!w_empty) wready[w_head] = bus.s_WREADY_i;
        w_pop    = s_wvalid && bus.s_WREADY_i && s_wlast;
    end

    // B steering: response goes to the B-order head; nothing is accepted
    // from the slave while no write is outstanding.
    always_comb begin
        bvalid   = '0;
        s_bready = 1'b0;
        if (!b_empty) begin
            bvalid[b_head] = bus.s_BVALID_i;
            s_bready       = bus.dsp_BREADY_i[b_head];
        end
        b_pop = bus.s_BVALID_i && s_bready;
    end

    assign bus.dsp_AWREADY_o = awready;
    assign bus.s_AWVALID_o   = aw_valid_reg;
    assign bus.s_AWID_o      = aw_id_reg;
    assign bus.s_AWADDR_o    = aw_addr_reg;
    assign bus.s_AWBURST_o   = aw_burst_reg;
    assign bus.s_AWLEN_o     = aw_len_reg;
    assign bus.s_AWSIZE_o    = aw_size_reg;

    assign bus.s_WVALID_o    = s_wvalid;
    assign bus.s_WDATA_o     = mst_wdata[w_head];
    assign bus.s_WLAST_o     = s_wlast;
    assign bus.dsp_WREADY_o  = wready;

    assign bus.dsp_BVALID_o  = bvalid;
    assign bus.dsp_BID_o     = bus.s_BID_i;
    assign bus.dsp_BRESP_o   = bus.s_BRESP_i;
    assign bus.s_BREADY_o    = s_bready;

endmodule

// File: tb/tb_sa_write_arbiter.sv
// Directed bench for sa_write_arbiter: a table of AW arbitration vectors
// followed by hand-written W ordering, outstanding cap, AW stall and
// mid-burst reset sequences.
module tb_sa_write_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sa_write_arbiter_if #(
        .MST_AMT(2), .DATA_WIDTH(32), .ADDR_WIDTH(32), .TRANS_MST_ID_W(5),
        .TRANS_BURST_W(2), .TRANS_DATA_LEN_W(3), .TRANS_DATA_SIZE_W(3),
        .TRANS_WR_RESP_W(2)
    ) bus ();

    sa_write_arbiter #(
        .MST_AMT(2), .OUTSTANDING_AMT(8), .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .TRANS_MST_ID_W(5), .TRANS_BURST_W(2), .TRANS_DATA_LEN_W(3),
        .TRANS_DATA_SIZE_W(3), .TRANS_WR_RESP_W(2)
    ) dut (
        .ACLK_i    (clk),
        .ARESETn_i (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [1:0] awv;
        logic [1:0] full;
        logic       awr;
        logic [1:0] exp_awready;
        logic       exp_awvalid;
        logic [4:0] exp_awid;
    } vec_t;

    vec_t vecs [11];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.dsp_AWVALID_i       = 2'b00;
        bus.dsp_AW_outst_full_i = 2'b00;
        bus.dsp_WDATA_i         = '0;
        bus.dsp_WLAST_i         = 2'b00;
        bus.dsp_WVALID_i        = 2'b00;
        bus.dsp_BREADY_i        = 2'b00;
        bus.s_AWREADY_i         = 1'b0;
        bus.s_WREADY_i          = 1'b0;
        bus.s_BID_i             = '0;
        bus.s_BRESP_i           = '0;
        bus.s_BVALID_i          = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt [2];
        logic [1:0] wr_seen;
        logic [31:0] exp_data;

        // Master 0: ID 03, addr 0x1000; master 1: ID 11, addr 0x2000; INCR, len 3, size 2
        bus.dsp_AWID_i    = {5'h11, 5'h03};
        bus.dsp_AWADDR_i  = {32'h0000_2000, 32'h0000_1000};
        bus.dsp_AWBURST_i = {2'b01, 2'b01};
        bus.dsp_AWLEN_i   = {3'd3, 3'd3};
        bus.dsp_AWSIZE_i  = {3'd2, 3'd2};

        vecs[0]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 5'h00};
        vecs[1]  = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b0, 5'h00};
        vecs[2]  = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 5'h03};
        vecs[3]  = '{2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 5'h11};
        vecs[4]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 5'h03};
        vecs[5]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 5'h03};
        vecs[6]  = '{2'b11, 2'b10, 1'b1, 2'b01, 1'b0, 5'h03};
        vecs[7]  = '{2'b11, 2'b10, 1'b1, 2'b01, 1'b1, 5'h03};
        vecs[8]  = '{2'b11, 2'b00, 1'b1, 2'b10, 1'b1, 5'h03};
        vecs[9]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 5'h11};
        vecs[10] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 5'h11};

        // Reset state, with traffic offered on W and B that must be gated off
        do_reset();
        bus.dsp_WVALID_i = 2'b11;
        bus.s_WREADY_i   = 1'b1;
        bus.s_BVALID_i   = 1'b1;
        bus.dsp_BREADY_i = 2'b11;
        settle();
        chk("rst_s_awvalid", 64'(bus.s_AWVALID_o), 64'(0));
        chk("rst_s_awid",    64'(bus.s_AWID_o),    64'(0));
        chk("rst_s_awaddr",  64'(bus.s_AWADDR_o),  64'(0));
        chk("rst_s_wvalid",  64'(bus.s_WVALID_o),  64'(0));
        chk("rst_wready",    64'(bus.dsp_WREADY_o), 64'(0));
        chk("rst_bvalid",    64'(bus.dsp_BVALID_o), 64'(0));
        chk("rst_s_bready",  64'(bus.s_BREADY_o),  64'(0));
        $display("[TB] reset state checked");
        idle();
        tick();

        // Table: round-robin alternation, then master 1 masked by outst_full
        for (int i = 0; i < 11; i++) begin
            bus.dsp_AWVALID_i       = vecs[i].awv;
            bus.dsp_AW_outst_full_i = vecs[i].full;
            bus.s_AWREADY_i         = vecs[i].awr;
            settle();
            chk($sformatf("vec%0d_awready", i), 64'(bus.dsp_AWREADY_o), 64'(vecs[i].exp_awready));
            chk($sformatf("vec%0d_awvalid", i), 64'(bus.s_AWVALID_o),   64'(vecs[i].exp_awvalid));
            chk($sformatf("vec%0d_awid", i),    64'(bus.s_AWID_o),      64'(vecs[i].exp_awid));
            $display("[TB] vec %0d awv=%b full=%b awready=%b s_awvalid=%b s_awid=%h",
                     i, vecs[i].awv, vecs[i].full, bus.dsp_AWREADY_o, bus.s_AWVALID_o, bus.s_AWID_o);
            tick();
        end

        // W ordering: AWs granted 1 then 0, W beats follow that order
        do_reset();
        bus.s_AWREADY_i   = 1'b1;
        bus.dsp_AWVALID_i = 2'b10;
        settle();
        chk("word_aw1", 64'(bus.dsp_AWREADY_o), 64'(2'b10));
        tick();
        bus.dsp_AWVALID_i = 2'b01;
        settle();
        chk("word_aw0", 64'(bus.dsp_AWREADY_o), 64'(2'b01));
        tick();
        bus.dsp_AWVALID_i = 2'b00;
        bus.s_WREADY_i    = 1'b1;
        cnt[0] = 0;
        cnt[1] = 0;
        for (int beat = 0; beat < 8; beat++) begin
            bus.dsp_WDATA_i  = {32'h0000_00B0 + 32'(cnt[1]), 32'h0000_00A0 + 32'(cnt[0])};
            bus.dsp_WLAST_i  = {cnt[1] == 3, cnt[0] == 3};
            bus.dsp_WVALID_i = {cnt[1] < 4, cnt[0] < 4};
            exp_data = (beat < 4) ? 32'h0000_00B0 + 32'(beat) : 32'h0000_00A0 + 32'(beat - 4);
            settle();
            chk($sformatf("w%0d_valid", beat), 64'(bus.s_WVALID_o), 64'(1));
            chk($sformatf("w%0d_data", beat),  64'(bus.s_WDATA_o),  64'(exp_data));
            chk($sformatf("w%0d_last", beat),  64'(bus.s_WLAST_o),  64'((beat % 4) == 3));
            chk($sformatf("w%0d_wready", beat), 64'(bus.dsp_WREADY_o),
                64'((beat < 4) ? 2'b10 : 2'b01));
            $display("[TB] W beat %0d data=%h last=%b wready=%b",
                     beat, bus.s_WDATA_o, bus.s_WLAST_o, bus.dsp_WREADY_o);
            wr_seen = bus.dsp_WREADY_o;
            tick();
            for (int m = 0; m < 2; m++)
                if (wr_seen[m] && bus.dsp_WVALID_i[m]) cnt[m]++;
        end
        bus.dsp_WVALID_i = 2'b00;
        bus.dsp_WLAST_i  = 2'b00;
        settle();
        chk("w_drained_valid",  64'(bus.s_WVALID_o),   64'(0));
        chk("w_drained_wready", 64'(bus.dsp_WREADY_o), 64'(0));
        tick();
        // B responses return to master 1 then master 0
        bus.s_WREADY_i   = 1'b0;
        bus.s_BVALID_i   = 1'b1;
        bus.s_BID_i      = 5'h11;
        bus.s_BRESP_i    = 2'b00;
        bus.dsp_BREADY_i = 2'b11;
        settle();
        chk("b0_bvalid", 64'(bus.dsp_BVALID_o), 64'(2'b10));
        chk("b0_bready", 64'(bus.s_BREADY_o),   64'(1));
        chk("b0_bid",    64'(bus.dsp_BID_o),    64'(5'h11));
        $display("[TB] B resp to mask %b", bus.dsp_BVALID_o);
        tick();
        bus.s_BID_i   = 5'h03;
        bus.s_BRESP_i = 2'b10;
        settle();
        chk("b1_bvalid", 64'(bus.dsp_BVALID_o), 64'(2'b01));
        chk("b1_bresp",  64'(bus.dsp_BRESP_o),  64'(2'b10));
        $display("[TB] B resp to mask %b", bus.dsp_BVALID_o);
        tick();
        settle();
        chk("b_empty_bvalid", 64'(bus.dsp_BVALID_o), 64'(0));
        chk("b_empty_bready", 64'(bus.s_BREADY_o),   64'(0));
        tick();

        // Outstanding cap: eight grants fill the FIFOs, the ninth waits
        do_reset();
        bus.s_AWREADY_i   = 1'b1;
        bus.dsp_AWVALID_i = 2'b01;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("cap_grant%0d", i), 64'(bus.dsp_AWREADY_o), 64'(2'b01));
            tick();
        end
        settle();
        chk("cap_full_noready", 64'(bus.dsp_AWREADY_o), 64'(0));
        $display("[TB] cap reached, awready=%b", bus.dsp_AWREADY_o);
        tick();
        bus.dsp_WVALID_i = 2'b01;
        bus.dsp_WLAST_i  = 2'b01;
        bus.s_WREADY_i   = 1'b1;
        bus.s_BVALID_i   = 1'b1;
        bus.s_BID_i      = 5'h03;
        bus.dsp_BREADY_i = 2'b01;
        settle();
        chk("cap_free_awready", 64'(bus.dsp_AWREADY_o), 64'(2'b01));
        chk("cap_free_bready",  64'(bus.s_BREADY_o),    64'(1));
        chk("cap_free_wvalid",  64'(bus.s_WVALID_o),    64'(1));
        tick();
        bus.dsp_WVALID_i = 2'b00;
        bus.dsp_WLAST_i  = 2'b00;
        bus.s_WREADY_i   = 1'b0;
        bus.s_BVALID_i   = 1'b0;
        bus.dsp_BREADY_i = 2'b00;
        settle();
        chk("cap_refull", 64'(bus.dsp_AWREADY_o), 64'(0));
        tick();

        // AW stall: payload holds while the slave is not ready
        do_reset();
        bus.s_AWREADY_i   = 1'b0;
        bus.dsp_AWVALID_i = 2'b11;
        settle();
        chk("stall_first", 64'(bus.dsp_AWREADY_o), 64'(2'b01));
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("stall%0d_awready", i), 64'(bus.dsp_AWREADY_o), 64'(0));
            chk($sformatf("stall%0d_awvalid", i), 64'(bus.s_AWVALID_o),   64'(1));
            chk($sformatf("stall%0d_awid", i),    64'(bus.s_AWID_o),      64'(5'h03));
            chk($sformatf("stall%0d_awaddr", i),  64'(bus.s_AWADDR_o),    64'(32'h1000));
            $display("[TB] stall cycle %0d s_awid=%h", i, bus.s_AWID_o);
            tick();
        end
        bus.s_AWREADY_i = 1'b1;
        settle();
        chk("stall_release_awready", 64'(bus.dsp_AWREADY_o), 64'(2'b10));
        tick();
        bus.dsp_AWVALID_i = 2'b00;
        settle();
        chk("stall_next_awid",   64'(bus.s_AWID_o),   64'(5'h11));
        chk("stall_next_awaddr", 64'(bus.s_AWADDR_o), 64'(32'h2000));
        chk("stall_next_awlen",  64'(bus.s_AWLEN_o),  64'(3'd3));
        tick();

        // Reset in the middle of a burst
        do_reset();
        bus.s_AWREADY_i   = 1'b1;
        bus.dsp_AWVALID_i = 2'b01;
        settle();
        chk("mid_aw", 64'(bus.dsp_AWREADY_o), 64'(2'b01));
        tick();
        bus.dsp_AWVALID_i = 2'b00;
        bus.dsp_WVALID_i  = 2'b01;
        bus.s_WREADY_i    = 1'b1;
        bus.dsp_WDATA_i   = {32'h0, 32'h0000_00A0};
        settle();
        chk("mid_beat0", 64'(bus.s_WVALID_o), 64'(1));
        tick();
        bus.dsp_WDATA_i = {32'h0, 32'h0000_00A1};
        settle();
        chk("mid_beat1", 64'(bus.s_WDATA_o), 64'(32'hA1));
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.s_BVALID_i   = 1'b1;
        bus.dsp_BREADY_i = 2'b11;
        settle();
        chk("mid_rst_wvalid",  64'(bus.s_WVALID_o),   64'(0));
        chk("mid_rst_wready",  64'(bus.dsp_WREADY_o), 64'(0));
        chk("mid_rst_awvalid", 64'(bus.s_AWVALID_o),  64'(0));
        chk("mid_rst_bvalid",  64'(bus.dsp_BVALID_o), 64'(0));
        chk("mid_rst_bready",  64'(bus.s_BREADY_o),   64'(0));
        $display("[TB] reset mid-burst, s_wvalid=%b", bus.s_WVALID_o);
        tick();
        idle();
        bus.s_AWREADY_i   = 1'b1;
        bus.dsp_AWVALID_i = 2'b11;
        settle();
        chk("mid_ptr0", 64'(bus.dsp_AWREADY_o), 64'(2'b01));
        tick();
        bus.dsp_AWVALID_i = 2'b10;
        settle();
        chk("mid_m1_grant", 64'(bus.dsp_AWREADY_o), 64'(2'b10));
        tick();
        bus.dsp_AWVALID_i = 2'b00;
        settle();
        chk("mid_m1_awid",    64'(bus.s_AWID_o),    64'(5'h11));
        chk("mid_m1_awvalid", 64'(bus.s_AWVALID_o), 64'(1));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
